lmsm_sequencer: RTL and testbench
=================================

LMSM_SEQUENCER -- requirements
Module: lmsm_sequencer

Interface
REQ-001 clk  in  1  single clock; all state updates on rising edge.
REQ-002 reset  in  1  synchronous, active-high reset.
REQ-003 start  in  1  valid LM/SM instruction presented in ID this cycle.
REQ-004 is_store  in  1  1 = SM, 0 = LM; sampled with start.
REQ-005 base_reg  in  3  base-address register index (RA field); sampled with start.
REQ-006 reg_list  in  8  register mask (bit i = Ri); sampled with start.
REQ-007 hold  in  1  downstream stall; freezes the sequencer.
REQ-008 flush  in  1  pipeline kill from the hazard controller; aborts the sequence.
REQ-009 m_inst  out  1  to the hazard controller; holds fetch/decode while further micro-ops remain.
REQ-010 busy  out  1  sequence in progress.
REQ-011 uop_valid  out  1  micro-op valid this cycle.
REQ-012 uop_store  out  1  micro-op is a store (SM), 0 = load (LM).
REQ-013 uop_rd  out  3  register loaded or stored by this micro-op.
REQ-014 uop_base  out  3  captured base_reg.
REQ-015 uop_offset  out  3  word offset from base (0..7).
REQ-016 uop_last  out  1  final micro-op of the sequence.

Function
REQ-017 FSM has two states, IDLE and ISSUE.
REQ-018 IDLE with start=1, flush=0 and reg_list!=0: capture is_store, base_reg and reg_list into pending mask; clear offset counter; go to ISSUE next cycle.
REQ-019 IDLE with start=1 and reg_list==0: stay IDLE, issue no micro-op (instruction retires as NOP).
REQ-020 ISSUE: uop_valid=1; uop_rd = index of the lowest set bit of the pending mask (R0 first); uop_offset = counter; uop_last=1 iff exactly one bit remains.
REQ-021 A micro-op is accepted when uop_valid=1 and hold=0; on acceptance clear that mask bit and increment the counter by 1 (3-bit; max value reached is 7, no wrap).
REQ-022 hold=1: all registers and outputs stay unchanged; the same micro-op is re-presented.
REQ-023 An accepted micro-op with uop_last=1 returns the FSM to IDLE next cycle; throughput is one micro-op per cycle; latency from start to first uop_valid is 1 cycle.
REQ-024 busy=1 in ISSUE, else 0.
REQ-025 m_inst = ISSUE and not uop_last; fetch resumes in the cycle the last micro-op is presented.
REQ-026 start while busy is ignored (upstream is held by m_inst).
REQ-027 flush=1 has priority over hold and start: go to IDLE next cycle and clear the mask and counter; a micro-op presented in a flush cycle is not counted as accepted.
REQ-028 Full mask 8'hFF yields 8 micro-ops R0..R7, offsets 0..7.
REQ-029 Outputs are registered-state decodes; outputs are never driven directly from inputs.

Reset
REQ-030 reset=1 at a clock edge: state=IDLE, mask=0, counter=0, captured fields=0, regardless of the current state (including mid-sequence).
REQ-031 During and after reset, before the next start: m_inst=0, busy=0, uop_valid=0, uop_store=0, uop_rd=0, uop_base=0, uop_offset=0, uop_last=0.
REQ-032 reset has priority over flush, hold and start.

Structure
REQ-033 The shared package holds the LM/SM opcode constants, the state encoding (IDLE, ISSUE) and the 3-bit register-index width constant.
REQ-034 One sub-module, lsb_find: a combinational 8-bit lowest-set-bit priority encoder that outputs a 3-bit index and a one-hot flag.
REQ-035 Hazard-controller integration: m_inst connects to that controller's multiple-instruction input; flush is driven from its IF/ID invalidation.

Verification
REQ-036 LM, base R3, list 8'b1000_0101, hold=0 -> cycles 1-3: (R0,off0), (R2,off1), (R7,off2,last); m_inst=1,1,0; IDLE in cycle 4.
REQ-037 SM, list 8'hFF, hold=1 in the 3rd micro-op cycle for 2 cycles -> R2/off2 presented for 3 cycles; 8 micro-ops total; uop_store=1 throughout.
REQ-038 start with list 8'h00 -> uop_valid, busy and m_inst stay 0.
REQ-039 list 8'b0011_0000, flush during the first micro-op -> IDLE next cycle; a new start with 8'h02 issues R1/off0/last.
REQ-040 reset asserted mid-sequence (list 8'h0F, after 2 micro-ops) -> all outputs 0 next cycle; start asserted during reset is ignored.
REQ-041 start held high in ISSUE with a different list -> the original sequence completes unchanged.

Source files
------------

// File: rtl/lmsm_sequencer_pkg.sv
// Shared definitions for the LM/SM micro-op sequencer: opcodes, FSM encoding,
// register-index width.
package lmsm_sequencer_pkg;

  localparam int REG_IDX_W = 3;
  localparam int REG_CNT   = 1 << REG_IDX_W;

  localparam logic [3:0] OP_LM = 4'b0110;
  localparam logic [3:0] OP_SM = 4'b0111;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_ISSUE = 1'b1
  } state_t;

endpackage

// File: rtl/lmsm_sequencer_lsb_find.sv
// Lowest-set-bit priority encoder over an 8-bit register mask; also flags
// whether exactly one bit is set.
module lsb_find
  import lmsm_sequencer_pkg::*;
(
  input  logic [REG_CNT-1:0]   i_vec,
  output logic [REG_IDX_W-1:0] o_idx,
  output logic                 o_onehot
);

  logic [REG_CNT-1:0] w_minus_one;

  assign w_minus_one = i_vec - 1'b1;
  assign o_onehot    = (i_vec != '0) && ((i_vec & w_minus_one) == '0);

  // Scan from the top so the lowest set bit is the final assignment.
  always_comb begin
    o_idx = '0;
    for (int i = REG_CNT - 1; i >= 0; i--) begin
      if (i_vec[i]) o_idx = REG_IDX_W'(i);
    end
  end

endmodule

// File: rtl/lmsm_sequencer.sv
// Expands one LM/SM instruction into one load/store micro-op per set bit of
// the register list, lowest register first, at one micro-op per cycle.
module lmsm_sequencer
  import lmsm_sequencer_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 is_store,
  input  logic [REG_IDX_W-1:0] base_reg,
  input  logic [REG_CNT-1:0]   reg_list,
  input  logic                 hold,
  input  logic                 flush,
  output logic                 m_inst,
  output logic                 busy,
  output logic                 uop_valid,
  output logic                 uop_store,
  output logic [REG_IDX_W-1:0] uop_rd,
  output logic [REG_IDX_W-1:0] uop_base,
  output logic [REG_IDX_W-1:0] uop_offset,
  output logic                 uop_last
);

  // Handshake: a micro-op transfers on any cycle with uop_valid=1 and hold=0;
  // flush kills the presented micro-op so it never counts as transferred.

  state_t               r_state;
  logic [REG_CNT-1:0]   r_mask;
  logic [REG_IDX_W-1:0] r_cnt;
  logic                 r_store;
  logic [REG_IDX_W-1:0] r_base;

  logic [REG_IDX_W-1:0] w_idx;
  logic                 w_onehot;
  logic                 w_issue;

  lsb_find u_lsb_find (
    .i_vec    (r_mask),
    .o_idx    (w_idx),
    .o_onehot (w_onehot)
  );

  assign w_issue = (r_state == ST_ISSUE);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_mask  <= '0;
      r_cnt   <= '0;
      r_store <= 1'b0;
      r_base  <= '0;
    end else if (flush) begin
      r_state <= ST_IDLE;
      r_mask  <= '0;
      r_cnt   <= '0;
      r_store <= 1'b0;
      r_base  <= '0;
    end else if (!hold) begin
      case (r_state)
        ST_IDLE: begin
          if (start && (reg_list != '0)) begin
            r_state <= ST_ISSUE;
            r_mask  <= reg_list;
            r_cnt   <= '0;
            r_store <= is_store;
            r_base  <= base_reg;
          end
        end
        ST_ISSUE: begin
          // x & (x-1) drops exactly the lowest set bit, the one just issued.
          r_mask <= r_mask & (r_mask - 1'b1);
          if (w_onehot) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign busy       = w_issue;
  assign uop_valid  = w_issue;
  assign uop_last   = w_issue && w_onehot;
  assign m_inst     = w_issue && !w_onehot;
  assign uop_store  = w_issue && r_store;
  assign uop_rd     = w_issue ? w_idx  : '0;
  assign uop_base   = w_issue ? r_base : '0;
  assign uop_offset = w_issue ? r_cnt  : '0;

endmodule

// File: tb/tb_lmsm_sequencer.sv
// Directed bench for lmsm_sequencer: each scenario drives one instruction and
// checks the full micro-op output tuple cycle by cycle.
module tb_lmsm_sequencer;

  logic       clk;
  logic       reset;
  logic       start;
  logic       is_store;
  logic [2:0] base_reg;
  logic [7:0] reg_list;
  logic       hold;
  logic       flush;
  logic       m_inst;
  logic       busy;
  logic       uop_valid;
  logic       uop_store;
  logic [2:0] uop_rd;
  logic [2:0] uop_base;
  logic [2:0] uop_offset;
  logic       uop_last;

  int total;
  int bad;

  logic [13:0] obs;
  assign obs = {m_inst, busy, uop_valid, uop_store, uop_rd, uop_base, uop_offset, uop_last};

  lmsm_sequencer dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .is_store   (is_store),
    .base_reg   (base_reg),
    .reg_list   (reg_list),
    .hold       (hold),
    .flush      (flush),
    .m_inst     (m_inst),
    .busy       (busy),
    .uop_valid  (uop_valid),
    .uop_store  (uop_store),
    .uop_rd     (uop_rd),
    .uop_base   (uop_base),
    .uop_offset (uop_offset),
    .uop_last   (uop_last)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  function automatic logic [13:0] mk(input logic m, input logic b, input logic v,
                                     input logic s, input logic [2:0] rd,
                                     input logic [2:0] base, input logic [2:0] off,
                                     input logic last);
    return {m, b, v, s, rd, base, off, last};
  endfunction

  // advance one clock; outputs are examined 1 time unit after the edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_start(input logic st, input logic [2:0] base, input logic [7:0] list);
    start    = 1'b1;
    is_store = st;
    base_reg = base;
    reg_list = list;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    tick();
    total++;
    if (obs !== 14'h0) begin
      bad++;
      $display("FAIL reset_outputs: got %h want %h", obs, 14'h0);
    end
    reset = 1'b0;
    tick();
    total++;
    if (obs !== 14'h0) begin
      bad++;
      $display("FAIL post_reset_idle: got %h want %h", obs, 14'h0);
    end
  endtask

  task automatic test_lm_basic();
    logic [13:0] exp_v [0:3];
    exp_v[0] = mk(1, 1, 1, 0, 3'd0, 3'd3, 3'd0, 0);
    exp_v[1] = mk(1, 1, 1, 0, 3'd2, 3'd3, 3'd1, 0);
    exp_v[2] = mk(0, 1, 1, 0, 3'd7, 3'd3, 3'd2, 1);
    exp_v[3] = 14'h0;
    drive_start(1'b0, 3'd3, 8'b1000_0101);
    tick();
    start = 1'b0;
    for (int c = 0; c < 4; c++) begin
      total++;
      if (obs !== exp_v[c]) begin
        bad++;
        $display("FAIL lm_basic cycle%0d: got %h want %h", c + 1, obs, exp_v[c]);
      end
      tick();
    end
  endtask

  task automatic test_sm_hold();
    logic [13:0] e;
    int r2_seen;
    int uops;
    r2_seen = 0;
    uops = 0;
    drive_start(1'b1, 3'd5, 8'hFF);
    tick();
    start = 1'b0;
    for (int k = 0; k < 8; k++) begin
      e = mk(k != 7, 1, 1, 1, 3'(k), 3'd5, 3'(k), k == 7);
      total++;
      if (obs !== e) begin
        bad++;
        $display("FAIL sm_full uop%0d: got %h want %h", k, obs, e);
      end
      if (uop_valid && uop_rd == 3'd2) r2_seen++;
      if (k == 2) begin
        hold = 1'b1;
        for (int h = 0; h < 2; h++) begin
          tick();
          total++;
          if (obs !== e) begin
            bad++;
            $display("FAIL sm_hold repeat%0d: got %h want %h", h, obs, e);
          end
          if (uop_valid && uop_rd == 3'd2) r2_seen++;
        end
        hold = 1'b0;
      end
      if (uop_valid) uops++;
      tick();
    end
    total++;
    if (r2_seen != 3) begin
      bad++;
      $display("FAIL sm_hold r2_cycles: got %0d want 3", r2_seen);
    end
    total++;
    if (uops != 8) begin
      bad++;
      $display("FAIL sm_full uop_count: got %0d want 8", uops);
    end
    total++;
    if (obs !== 14'h0) begin
      bad++;
      $display("FAIL sm_full idle_after: got %h want %h", obs, 14'h0);
    end
  endtask

  task automatic test_empty_list();
    drive_start(1'b0, 3'd4, 8'h00);
    tick();
    start = 1'b0;
    for (int c = 0; c < 2; c++) begin
      total++;
      if (obs !== 14'h0) begin
        bad++;
        $display("FAIL empty_list cycle%0d: got %h want %h", c, obs, 14'h0);
      end
      tick();
    end
  endtask

  task automatic test_flush();
    logic [13:0] e;
    drive_start(1'b0, 3'd1, 8'b0011_0000);
    tick();
    start = 1'b0;
    e = mk(1, 1, 1, 0, 3'd4, 3'd1, 3'd0, 0);
    total++;
    if (obs !== e) begin
      bad++;
      $display("FAIL flush first_uop: got %h want %h", obs, e);
    end
    flush = 1'b1;
    tick();
    flush = 1'b0;
    total++;
    if (obs !== 14'h0) begin
      bad++;
      $display("FAIL flush to_idle: got %h want %h", obs, 14'h0);
    end
    drive_start(1'b0, 3'd6, 8'h02);
    tick();
    start = 1'b0;
    e = mk(0, 1, 1, 0, 3'd1, 3'd6, 3'd0, 1);
    total++;
    if (obs !== e) begin
      bad++;
      $display("FAIL flush restart_uop: got %h want %h", obs, e);
    end
    tick();
    total++;
    if (obs !== 14'h0) begin
      bad++;
      $display("FAIL flush restart_done: got %h want %h", obs, 14'h0);
    end
  endtask

  task automatic test_reset_mid();
    logic [13:0] e;
    drive_start(1'b1, 3'd2, 8'h0F);
    tick();
    start = 1'b0;
    for (int k = 0; k < 2; k++) begin
      e = mk(1, 1, 1, 1, 3'(k), 3'd2, 3'(k), 0);
      total++;
      if (obs !== e) begin
        bad++;
        $display("FAIL reset_mid uop%0d: got %h want %h", k, obs, e);
      end
      tick();
    end
    reset = 1'b1;
    drive_start(1'b1, 3'd7, 8'hFF);
    for (int c = 0; c < 2; c++) begin
      tick();
      total++;
      if (obs !== 14'h0) begin
        bad++;
        $display("FAIL reset_mid in_reset%0d: got %h want %h", c, obs, 14'h0);
      end
    end
    reset = 1'b0;
    start = 1'b0;
    tick();
    total++;
    if (obs !== 14'h0) begin
      bad++;
      $display("FAIL reset_mid after_release: got %h want %h", obs, 14'h0);
    end
  endtask

  task automatic test_start_while_busy();
    logic [13:0] e;
    drive_start(1'b0, 3'd4, 8'b0000_0110);
    tick();
    drive_start(1'b1, 3'd7, 8'hF0);
    e = mk(1, 1, 1, 0, 3'd1, 3'd4, 3'd0, 0);
    total++;
    if (obs !== e) begin
      bad++;
      $display("FAIL busy_start uop0: got %h want %h", obs, e);
    end
    tick();
    e = mk(0, 1, 1, 0, 3'd2, 3'd4, 3'd1, 1);
    total++;
    if (obs !== e) begin
      bad++;
      $display("FAIL busy_start uop1: got %h want %h", obs, e);
    end
    start = 1'b0;
    tick();
    total++;
    if (obs !== 14'h0) begin
      bad++;
      $display("FAIL busy_start done: got %h want %h", obs, 14'h0);
    end
  endtask

  initial begin
    total    = 0;
    bad      = 0;
    reset    = 1'b1;
    start    = 1'b0;
    is_store = 1'b0;
    base_reg = 3'd0;
    reg_list = 8'h00;
    hold     = 1'b0;
    flush    = 1'b0;
    #1;
    test_reset();
    test_lm_basic();
    test_sm_hold();
    test_empty_list();
    test_flush();
    test_reset_mid();
    test_start_while_busy();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
